// File: rtl/game_pkg.sv
// Shared definitions for the runner game controller and the sprite stages:
// state encoding, default tuning constants and a small speed helper.
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HIT  = 2'd2,
      ST_OVER = 2'd3
   } game_state_t;

   localparam int DEF_SCROLL_W      = 32;
   localparam int DEF_START_SPEED   = 3;
   localparam int DEF_MAX_SPEED     = 15;
   localparam int DEF_SPEED_FRAMES  = 600;
   localparam int DEF_HIT_THRESHOLD = 16;
   localparam int DEF_HIT_FRAMES    = 90;

   // Frame counter is shared between the RUN speed-up interval and the HIT timer.
   localparam int FRAME_CNT_W = 16;

   // One speed step, clamped at the ceiling.
   function automatic logic [3:0] speed_step(input logic [3:0] cur, input logic [3:0] ceiling);
      return (cur >= ceiling) ? ceiling : cur + 4'd1;
   endfunction

endpackage

// File: rtl/game_state_ctrl_overlap_counter.sv
// Per-frame collision pixel counter. Counts cycles where the character and
// the encounter sprite both cover a visible pixel, saturating at the hit
// threshold. The frame tick restarts the count; a pixel in that same cycle
// belongs to the new frame.
module overlap_counter
   import game_pkg::*;
#(
   parameter int HIT_THRESHOLD = DEF_HIT_THRESHOLD
) (
   input  logic clock,
   input  logic reset,
   input  logic i_frame_tick,
   input  logic i_pixel,
   output logic o_hit
);

   localparam int CNT_W = $clog2(HIT_THRESHOLD + 1);
   localparam logic [CNT_W-1:0] THR = CNT_W'(HIT_THRESHOLD);

   logic [CNT_W-1:0] r_count;

   // Saturating overlap count, restarted on every frame tick.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (reset) begin
         r_count <= '0;
      end else if (i_frame_tick) begin
         r_count <= i_pixel ? CNT_W'(1) : '0;
      end else if (i_pixel && (r_count != THR)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   // Hit is read by the FSM in the tick cycle, i.e. before the restart lands.
   assign o_hit = (r_count == THR);

endmodule

// File: rtl/game_state_ctrl.sv
// Per-frame game controller: jump key synchroniser, frame tick, collision
// detection, IDLE/RUN/HIT/OVER state machine and the scroll/speed/score path.
module game_state_ctrl
   import game_pkg::*;
#(
   parameter int SCROLL_W      = DEF_SCROLL_W,
   parameter int START_SPEED   = DEF_START_SPEED,
   parameter int MAX_SPEED     = DEF_MAX_SPEED,
   parameter int SPEED_FRAMES  = DEF_SPEED_FRAMES,
   parameter int HIT_THRESHOLD = DEF_HIT_THRESHOLD,
   parameter int HIT_FRAMES    = DEF_HIT_FRAMES
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [11:0]         display_col,
   input  logic [10:0]         display_row,
   input  logic                visible,
   input  logic                char_visible,
   input  logic                enc1_visible,
   input  logic                jump_key,
   output logic [SCROLL_W-1:0] scroll_offset,
   output logic [3:0]          speed,
   output logic [15:0]         score,
   output logic                running,
   output logic                game_over,
   output logic                flash
);

   localparam logic [3:0]             START_SPD  = 4'(START_SPEED);
   localparam logic [3:0]             MAX_SPD    = 4'(MAX_SPEED);
   localparam logic [FRAME_CNT_W-1:0] SPEED_LAST = FRAME_CNT_W'(SPEED_FRAMES - 1);
   localparam logic [FRAME_CNT_W-1:0] HIT_LAST   = FRAME_CNT_W'(HIT_FRAMES - 1);

   logic                   r_key_s1, r_key_s2, r_key_s3;
   logic                   r_frame_tick;
   game_state_t            r_state;
   logic [SCROLL_W-1:0]    r_scroll;
   logic [3:0]             r_speed;
   logic [15:0]            r_score;
   logic [FRAME_CNT_W-1:0] r_frame_cnt;
   logic                   r_running, r_game_over, r_flash;

   logic                   w_key_rise;
   logic                   w_pixel;
   logic                   w_hit;
   game_state_t            w_next_state;
   logic [SCROLL_W-1:0]    w_next_scroll;
   logic [3:0]             w_next_speed;
   logic [15:0]            w_next_score;
   logic [FRAME_CNT_W-1:0] w_next_frame_cnt;

   // Two-flop synchroniser for the raw key plus one flop for edge detection.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_key_s1 <= 1'b0;
         r_key_s2 <= 1'b0;
         r_key_s3 <= 1'b0;
      end else begin
         r_key_s1 <= jump_key;
         r_key_s2 <= r_key_s1;
         r_key_s3 <= r_key_s2;
      end
   end

   assign w_key_rise = r_key_s2 & ~r_key_s3;

   // Frame tick: one cycle after the raster origin is sampled.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_frame_tick <= 1'b0;
      else       r_frame_tick <= (display_col == 12'd0) && (display_row == 11'd0);
   end

   assign w_pixel = visible & char_visible & enc1_visible;

   overlap_counter #(
      .HIT_THRESHOLD(HIT_THRESHOLD)
   ) u_overlap (
      .clock       (clock),
      .reset       (reset),
      .i_frame_tick(r_frame_tick),
      .i_pixel     (w_pixel),
      .o_hit       (w_hit)
   );

   // Next state and next scroll/speed/score/frame count.
   always_comb begin
      // NOTE: defaults first so every path assigns every signal and no latch is inferred.
      w_next_state     = r_state;
      w_next_scroll    = r_scroll;
      w_next_speed     = r_speed;
      w_next_score     = r_score;
      w_next_frame_cnt = r_frame_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_key_rise) begin
               w_next_state     = ST_RUN;
               w_next_speed     = START_SPD;
               w_next_score     = 16'd0;
               w_next_frame_cnt = '0;
            end
         end
         ST_RUN: begin
            if (r_frame_tick) begin
               if (w_hit) begin
                  w_next_state     = ST_HIT;
                  w_next_frame_cnt = '0;
               end else begin
                  w_next_scroll = r_scroll + SCROLL_W'(r_speed);
                  w_next_score  = (r_score == 16'hFFFF) ? r_score : r_score + 16'd1;
                  if (r_frame_cnt == SPEED_LAST) begin
                     w_next_frame_cnt = '0;
                     w_next_speed     = speed_step(r_speed, MAX_SPD);
                  end else begin
                     w_next_frame_cnt = r_frame_cnt + FRAME_CNT_W'(1);
                  end
               end
            end
         end
         ST_HIT: begin
            if (r_frame_tick) begin
               if (r_frame_cnt == HIT_LAST) begin
                  w_next_state     = ST_OVER;
                  w_next_frame_cnt = '0;
               end else begin
                  w_next_frame_cnt = r_frame_cnt + FRAME_CNT_W'(1);
               end
            end
         end
         ST_OVER: begin
            if (w_key_rise) begin
               w_next_state     = ST_IDLE;
               w_next_scroll    = '0;
               w_next_score     = 16'd0;
               w_next_speed     = START_SPD;
               w_next_frame_cnt = '0;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_scroll    <= '0;
         r_speed     <= START_SPD;
         r_score     <= 16'd0;
         r_frame_cnt <= '0;
      end else begin
         r_state     <= w_next_state;
         r_scroll    <= w_next_scroll;
         r_speed     <= w_next_speed;
         r_score     <= w_next_score;
         r_frame_cnt <= w_next_frame_cnt;
      end
   end

   // Status flags, registered from the current state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_running   <= 1'b0;
         r_game_over <= 1'b0;
         r_flash     <= 1'b0;
      end else begin
         r_running   <= (r_state == ST_RUN);
         r_game_over <= (r_state == ST_OVER);
         r_flash     <= (r_state == ST_HIT) && r_frame_cnt[3];
      end
   end

   assign scroll_offset = r_scroll;
   assign speed         = r_speed;
   assign score         = r_score;
   assign running       = r_running;
   assign game_over     = r_game_over;
   assign flash         = r_flash;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl. Three instances share stimulus: default build,
// an 8-bit scroll build (wrap) and a fast speed-up build (SPEED_FRAMES=4).
// A frame-level model pushes expectations into a scoreboard queue as each
// stimulus step is driven; they are popped and compared once outputs settle.
module tb_game_state_ctrl;

   localparam int N = 3;

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] display_col;
   logic [10:0] display_row;
   logic        visible, char_visible, enc1_visible, jump_key;

   logic [31:0] scr0, scr2;
   logic [7:0]  scr1;
   logic [3:0]  spd0, spd1, spd2;
   logic [15:0] sc0, sc1, sc2;
   logic        run0, run1, run2, ov0, ov1, ov2, fl0, fl1, fl2;

   game_state_ctrl dut0 (
      .clock(clock), .reset(reset), .display_col(display_col), .display_row(display_row),
      .visible(visible), .char_visible(char_visible), .enc1_visible(enc1_visible),
      .jump_key(jump_key), .scroll_offset(scr0), .speed(spd0), .score(sc0),
      .running(run0), .game_over(ov0), .flash(fl0));

   game_state_ctrl #(.SCROLL_W(8)) dut1 (
      .clock(clock), .reset(reset), .display_col(display_col), .display_row(display_row),
      .visible(visible), .char_visible(char_visible), .enc1_visible(enc1_visible),
      .jump_key(jump_key), .scroll_offset(scr1), .speed(spd1), .score(sc1),
      .running(run1), .game_over(ov1), .flash(fl1));

   game_state_ctrl #(.SPEED_FRAMES(4)) dut2 (
      .clock(clock), .reset(reset), .display_col(display_col), .display_row(display_row),
      .visible(visible), .char_visible(char_visible), .enc1_visible(enc1_visible),
      .jump_key(jump_key), .scroll_offset(scr2), .speed(spd2), .score(sc2),
      .running(run2), .game_over(ov2), .flash(fl2));

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]  st;
      logic [31:0] scroll;
      int          speed;
      int          score;
      int          fcnt;
   } mdl_t;

   typedef struct {
      int          inst;
      logic [31:0] scroll;
      logic [3:0]  speed;
      logic [15:0] score;
      logic        running;
      logic        over;
      logic        flash;
   } exp_t;

   int          sf_tab   [N] = '{600, 600, 4};
   logic [31:0] mask_tab [N] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FFFF};
   mdl_t        m [N];
   exp_t        sb [$];
   int          total = 0;
   int          bad   = 0;
   string       phase = "init";

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s (%s): got %0h expected %0h", tag, phase, got, want);
      end
   endtask

   // ---------------- model ----------------
   function automatic mdl_t m_reset();
      mdl_t s;
      s.st = 2'd0; s.scroll = 32'd0; s.speed = 3; s.score = 0; s.fcnt = 0;
      return s;
   endfunction

   function automatic mdl_t m_frame(mdl_t s, int sf, logic [31:0] mask, bit hit);
      case (s.st)
         2'd1: begin
            if (hit) begin
               s.st = 2'd2; s.fcnt = 0;
            end else begin
               s.scroll = (s.scroll + s.speed) & mask;
               if (s.score < 65535) s.score++;
               if (s.fcnt == sf - 1) begin
                  s.fcnt = 0;
                  if (s.speed < 15) s.speed++;
               end else s.fcnt++;
            end
         end
         2'd2: begin
            if (s.fcnt == 89) begin s.st = 2'd3; s.fcnt = 0; end
            else s.fcnt++;
         end
         default: ;
      endcase
      return s;
   endfunction

   function automatic mdl_t m_key(mdl_t s);
      if (s.st == 2'd0) begin
         s.st = 2'd1; s.speed = 3; s.score = 0; s.fcnt = 0;
      end else if (s.st == 2'd3) begin
         s.st = 2'd0; s.scroll = 32'd0; s.score = 0; s.speed = 3; s.fcnt = 0;
      end
      return s;
   endfunction

   task automatic model_frames(input int n, input bit hit);
      for (int k = 0; k < n; k++)
         for (int i = 0; i < N; i++) m[i] = m_frame(m[i], sf_tab[i], mask_tab[i], hit);
   endtask

   // ---------------- scoreboard ----------------
   task automatic push_expect();
      for (int i = 0; i < N; i++) begin
         exp_t e;
         e.inst    = i;
         e.scroll  = m[i].scroll;
         e.speed   = m[i].speed[3:0];
         e.score   = m[i].score[15:0];
         e.running = (m[i].st == 2'd1);
         e.over    = (m[i].st == 2'd3);
         e.flash   = (m[i].st == 2'd2) && m[i].fcnt[3];
         sb.push_back(e);
      end
   endtask

   task automatic compare_out();
      exp_t e;
      logic [31:0] g_scr;
      logic [3:0]  g_spd;
      logic [15:0] g_sc;
      logic        g_run, g_ov, g_fl;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.inst)
            0:       begin g_scr = scr0;          g_spd = spd0; g_sc = sc0; g_run = run0; g_ov = ov0; g_fl = fl0; end
            1:       begin g_scr = {24'd0, scr1}; g_spd = spd1; g_sc = sc1; g_run = run1; g_ov = ov1; g_fl = fl1; end
            default: begin g_scr = scr2;          g_spd = spd2; g_sc = sc2; g_run = run2; g_ov = ov2; g_fl = fl2; end
         endcase
         check($sformatf("u%0d.scroll", e.inst),  g_scr, e.scroll);
         check($sformatf("u%0d.speed", e.inst),   32'(g_spd), 32'(e.speed));
         check($sformatf("u%0d.score", e.inst),   32'(g_sc), 32'(e.score));
         check($sformatf("u%0d.running", e.inst), 32'(g_run), 32'(e.running));
         check($sformatf("u%0d.over", e.inst),    32'(g_ov), 32'(e.over));
         check($sformatf("u%0d.flash", e.inst),   32'(g_fl), 32'(e.flash));
      end
   endtask

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic set_pix(input logic vis, input logic ovl);
      visible = vis; char_visible = ovl; enc1_visible = ovl;
   endtask

   // npix overlap cycles mid-frame, then one raster-origin cycle, then settle.
   task automatic frame_pix(input int npix, input logic vis);
      model_frames(1, vis && (npix >= 16));
      push_expect();
      display_col = 12'd7; display_row = 11'd3;
      set_pix(vis, 1'b1);
      repeat (npix) cyc();
      set_pix(1'b0, 1'b0);
      display_col = 12'd0; display_row = 11'd0;
      cyc();
      display_col = 12'd7; display_row = 11'd3;
      repeat (3) cyc();
      compare_out();
   endtask

   task automatic frame(input int npix);
      frame_pix(npix, 1'b1);
   endtask

   // Raster origin held for n cycles: n back-to-back frame ticks.
   task automatic frames_fast(input int n);
      model_frames(n, 1'b0);
      push_expect();
      display_col = 12'd0; display_row = 11'd0;
      repeat (n) cyc();
      display_col = 12'd7; display_row = 11'd3;
      repeat (3) cyc();
      compare_out();
   endtask

   task automatic press_key();
      for (int i = 0; i < N; i++) m[i] = m_key(m[i]);
      push_expect();
      jump_key = 1'b1;
      repeat (6) cyc();
      jump_key = 1'b0;
      repeat (3) cyc();
      compare_out();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog (%s): got timeout expected finish", phase);
      $fatal(1, "watchdog expired");
   end

   logic [31:0] frozen;

   initial begin
      reset = 1'b1; jump_key = 1'b0;
      display_col = 12'd7; display_row = 11'd3;
      set_pix(1'b0, 1'b0);
      for (int i = 0; i < N; i++) m[i] = m_reset();
      repeat (3) cyc();

      phase = "reset";
      push_expect();
      compare_out();
      reset = 1'b0;
      repeat (2) cyc();

      phase = "start";
      jump_key = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc();
         if (run0) break;
      end
      check("run_latency", 32'(run0), 32'd1);
      jump_key = 1'b0;
      repeat (3) cyc();
      for (int i = 0; i < N; i++) m[i] = m_key(m[i]);
      push_expect();
      compare_out();

      phase = "run10";
      for (int k = 0; k < 10; k++) begin
         frame(0);
         if (k == 3) check("fast_speed_after4", 32'(spd2), 32'd4);
      end
      check("scroll_after10", scr0, 32'd30);
      check("score_after10", 32'(sc0), 32'd10);

      phase = "speedup";
      press_key();
      for (int k = 0; k < 38; k++) frame(0);
      check("fast_speed_after48", 32'(spd2), 32'd15);
      for (int k = 0; k < 4; k++) frame(0);
      check("fast_speed_ceiling", 32'(spd2), 32'd15);

      phase = "reset_mid_run";
      #2 reset = 1'b1;
      #1;
      for (int i = 0; i < N; i++) m[i] = m_reset();
      push_expect();
      compare_out();
      cyc(); cyc();
      reset = 1'b0;
      cyc();
      press_key();

      phase = "overlap";
      frame(3);
      frame_pix(20, 1'b0);
      frame(10);
      frame(10);
      frame(15);
      check("run_after15", 32'(run0), 32'd1);
      frozen = scr0;
      frame(16);
      check("scroll_frozen_on_hit", scr0, frozen);
      check("left_run_on_hit", 32'(run0), 32'd0);

      phase = "hit";
      for (int k = 0; k < 90; k++) begin
         frame(0);
         if (k == 40) press_key();
      end
      check("game_over_after90", 32'(ov0), 32'd1);
      check("scroll_frozen_in_hit", scr0, frozen);

      phase = "over";
      press_key();
      check("over_to_idle_score", 32'(sc0), 32'd0);
      check("over_to_idle_scroll", scr0, 32'd0);
      frame(0);

      phase = "wrap_sat";
      press_key();
      frames_fast(85);
      check("narrow_scroll_255", 32'(scr1), 32'd255);
      frames_fast(1);
      check("narrow_scroll_wrap", 32'(scr1), 32'd2);
      frames_fast(65533 - 86);
      check("score_fffd", 32'(sc0), 32'h0000_FFFD);
      frames_fast(3);
      check("score_saturated", 32'(sc0), 32'h0000_FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
